// File: rtl/rv32i_lsu_pkg.sv
// Shared constants and types for the RV32I load/store unit: funct3 encodings,
// exception causes, FSM states and the access-width decode.
package rv32i_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] EXC_LOAD_MISALIGNED   = 4'd4;
  localparam logic [3:0] EXC_LOAD_ACCESS_FAULT = 4'd5;
  localparam logic [3:0] EXC_STORE_MISALIGNED  = 4'd6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    DRAIN   = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    W_BYTE = 2'd0,
    W_HALF = 2'd1,
    W_WORD = 2'd2
  } access_width_e;

  // Unassigned encodings (011, 110, 111) fall through to a full-word access.
  function automatic access_width_e decode_width(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return W_BYTE;
      F3_H, F3_HU: return W_HALF;
      F3_W:        return W_WORD;
      default:     return W_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundle of the execute-side request, writeback-side response/exception and
// data-RAM controller signals seen by the load/store unit.
interface load_store_unit_if #(
  parameter int XLEN      = 32,
  parameter int ADDRWIDTH = 12
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_is_store;
  logic [2:0]           req_funct3;
  logic [XLEN-1:0]      req_base;
  logic [11:0]          req_imm;
  logic [XLEN-1:0]      req_wdata;
  logic [4:0]           req_rd;
  logic                 flush;

  logic                 resp_valid;
  logic                 resp_is_load;
  logic [XLEN-1:0]      resp_rdata;
  logic [4:0]           resp_rd;
  logic                 exc_valid;
  logic [3:0]           exc_cause;
  logic [XLEN-1:0]      exc_addr;

  logic [ADDRWIDTH-1:0] mem_addr;
  logic [XLEN-1:0]      mem_wrData;
  logic                 mem_wrEn;
  logic                 mem_rdEn;
  logic                 mem_byteEn;
  logic                 mem_halfEn;
  logic                 mem_wordEn;
  logic                 mem_unsignedEn;
  logic [XLEN-1:0]      mem_dataOut;
  logic                 mem_outEn;

  // Environment side: execute stage, writeback and the RAM controller.
  modport master (
    output req_valid, req_is_store, req_funct3, req_base, req_imm, req_wdata, req_rd, flush,
    output mem_dataOut, mem_outEn,
    input  req_ready, resp_valid, resp_is_load, resp_rdata, resp_rd,
    input  exc_valid, exc_cause, exc_addr,
    input  mem_addr, mem_wrData, mem_wrEn, mem_rdEn,
    input  mem_byteEn, mem_halfEn, mem_wordEn, mem_unsignedEn
  );

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_base, req_imm, req_wdata, req_rd, flush,
    input  mem_dataOut, mem_outEn,
    output req_ready, resp_valid, resp_is_load, resp_rdata, resp_rd,
    output exc_valid, exc_cause, exc_addr,
    output mem_addr, mem_wrData, mem_wrEn, mem_rdEn,
    output mem_byteEn, mem_halfEn, mem_wordEn, mem_unsignedEn
  );

endinterface

// File: rtl/lsu_addr_check.sv
// Combinational front end of the LSU: effective address, alignment check,
// width/sign flag decode and low-lane store-data justification.
module lsu_addr_check
  import rv32i_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] base,
  input  logic [11:0]     imm,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] eff_addr,
  output logic            misaligned,
  output logic            byte_en,
  output logic            half_en,
  output logic            word_en,
  output logic            unsigned_en,
  output logic [XLEN-1:0] store_data
);

  access_width_e width;

  always_comb begin
    width       = decode_width(funct3);
    // Address arithmetic wraps modulo 2^XLEN; overflow is not a fault.
    eff_addr    = base + {{(XLEN-12){imm[11]}}, imm};
    byte_en     = (width == W_BYTE);
    half_en     = (width == W_HALF);
    word_en     = (width == W_WORD);
    unsigned_en = funct3[2];
    misaligned  = 1'b0;
    store_data  = wdata;
    case (width)
      W_BYTE: store_data = {{(XLEN-8){1'b0}}, wdata[7:0]};
      W_HALF: begin
        store_data = {{(XLEN-16){1'b0}}, wdata[15:0]};
        misaligned = eff_addr[0];
      end
      default: misaligned = |eff_addr[1:0];
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: accepts one load/store at a time, strobes the
// data-RAM controller, waits for read data and reports completion or exception.
module load_store_unit
  import rv32i_lsu_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus,
  output lsu_state_e       dbg_state
);

  localparam int ADDRWIDTH = $clog2(DEPTH);
  localparam int CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [XLEN-1:0] ac_eff_addr;
  logic [XLEN-1:0] ac_store_data;
  logic            ac_misaligned;
  logic            ac_byte_en;
  logic            ac_half_en;
  logic            ac_word_en;
  logic            ac_unsigned_en;

  lsu_addr_check #(.XLEN(XLEN)) u_addr_check (
    .base        (bus.req_base),
    .imm         (bus.req_imm),
    .funct3      (bus.req_funct3),
    .wdata       (bus.req_wdata),
    .eff_addr    (ac_eff_addr),
    .misaligned  (ac_misaligned),
    .byte_en     (ac_byte_en),
    .half_en     (ac_half_en),
    .word_en     (ac_word_en),
    .unsigned_en (ac_unsigned_en),
    .store_data  (ac_store_data)
  );

  lsu_state_e      state_q,        state_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic [4:0]      rd_q,           rd_d;
  logic [XLEN-1:0] eff_addr_q,     eff_addr_d;
  logic [XLEN-1:0] wr_data_q,      wr_data_d;
  logic            wr_en_q,        wr_en_d;
  logic            rd_en_q,        rd_en_d;
  logic            byte_en_q,      byte_en_d;
  logic            half_en_q,      half_en_d;
  logic            word_en_q,      word_en_d;
  logic            unsigned_en_q,  unsigned_en_d;
  logic            resp_valid_q,   resp_valid_d;
  logic            resp_is_load_q, resp_is_load_d;
  logic [XLEN-1:0] rdata_q,        rdata_d;
  logic            exc_valid_q,    exc_valid_d;
  logic [3:0]      exc_cause_q,    exc_cause_d;
  logic [XLEN-1:0] exc_addr_q,     exc_addr_d;

  logic accept;
  logic timeout_hit;

  // Handshake: an op transfers on a clock edge where req_valid && req_ready,
  // unless flush is high in that same cycle. req_ready is high only in IDLE and
  // never depends on req_valid; execute must hold its op stable until it transfers.
  assign accept      = bus.req_valid && (state_q == IDLE) && !bus.flush;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rd_d           = rd_q;
    eff_addr_d     = eff_addr_q;
    wr_data_d      = wr_data_q;
    rdata_d        = rdata_q;
    exc_cause_d    = exc_cause_q;
    exc_addr_d     = exc_addr_q;
    wr_en_d        = 1'b0;
    rd_en_d        = 1'b0;
    byte_en_d      = 1'b0;
    half_en_d      = 1'b0;
    word_en_d      = 1'b0;
    unsigned_en_d  = 1'b0;
    resp_valid_d   = 1'b0;
    resp_is_load_d = 1'b0;
    exc_valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (ac_misaligned) begin
            exc_valid_d = 1'b1;
            exc_cause_d = bus.req_is_store ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED;
            exc_addr_d  = ac_eff_addr;
          end else begin
            eff_addr_d    = ac_eff_addr;
            byte_en_d     = ac_byte_en;
            half_en_d     = ac_half_en;
            word_en_d     = ac_word_en;
            unsigned_en_d = ac_unsigned_en;
            if (bus.req_is_store) begin
              // Stores complete on the strobe; the controller gives no write ack.
              wr_en_d      = 1'b1;
              wr_data_d    = ac_store_data;
              resp_valid_d = 1'b1;
            end else begin
              rd_en_d = 1'b1;
              rd_d    = bus.req_rd;
              state_d = RD_WAIT;
            end
          end
        end
      end

      RD_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.flush) begin
          state_d = (bus.mem_outEn || timeout_hit) ? IDLE : DRAIN;
        end else if (bus.mem_outEn) begin
          rdata_d        = bus.mem_dataOut;
          resp_valid_d   = 1'b1;
          resp_is_load_d = 1'b1;
          state_d        = IDLE;
        end else if (timeout_hit) begin
          exc_valid_d = 1'b1;
          exc_cause_d = EXC_LOAD_ACCESS_FAULT;
          exc_addr_d  = eff_addr_q;
          state_d     = IDLE;
        end
      end

      // The squashed read is still owed a data beat; consume it without reporting.
      DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.mem_outEn || timeout_hit) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rd_q           <= '0;
      eff_addr_q     <= '0;
      wr_data_q      <= '0;
      wr_en_q        <= 1'b0;
      rd_en_q        <= 1'b0;
      byte_en_q      <= 1'b0;
      half_en_q      <= 1'b0;
      word_en_q      <= 1'b0;
      unsigned_en_q  <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_is_load_q <= 1'b0;
      rdata_q        <= '0;
      exc_valid_q    <= 1'b0;
      exc_cause_q    <= '0;
      exc_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rd_q           <= rd_d;
      eff_addr_q     <= eff_addr_d;
      wr_data_q      <= wr_data_d;
      wr_en_q        <= wr_en_d;
      rd_en_q        <= rd_en_d;
      byte_en_q      <= byte_en_d;
      half_en_q      <= half_en_d;
      word_en_q      <= word_en_d;
      unsigned_en_q  <= unsigned_en_d;
      resp_valid_q   <= resp_valid_d;
      resp_is_load_q <= resp_is_load_d;
      rdata_q        <= rdata_d;
      exc_valid_q    <= exc_valid_d;
      exc_cause_q    <= exc_cause_d;
      exc_addr_q     <= exc_addr_d;
    end
  end

  assign bus.req_ready      = (state_q == IDLE);
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_is_load   = resp_is_load_q;
  assign bus.resp_rdata     = rdata_q;
  assign bus.resp_rd        = rd_q;
  assign bus.exc_valid      = exc_valid_q;
  assign bus.exc_cause      = exc_cause_q;
  assign bus.exc_addr       = exc_addr_q;
  assign bus.mem_addr       = eff_addr_q[ADDRWIDTH-1:0];
  assign bus.mem_wrData     = wr_data_q;
  assign bus.mem_wrEn       = wr_en_q;
  assign bus.mem_rdEn       = rd_en_q;
  assign bus.mem_byteEn     = byte_en_q;
  assign bus.mem_halfEn     = half_en_q;
  assign bus.mem_wordEn     = word_en_q;
  assign bus.mem_unsignedEn = unsigned_en_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a driver issues ops and pushes expected
// strobes/responses/exceptions; a monitor pops and compares as the DUT emits them.
module tb_load_store_unit;
  import rv32i_lsu_pkg::*;

  localparam int XLEN    = 32;
  localparam int AW      = 12;
  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  lsu_state_e dbg_state;

  load_store_unit_if #(.XLEN(XLEN), .ADDRWIDTH(AW)) bus ();

  load_store_unit #(.DEPTH(4096), .XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  // strobe entry: {wrEn, rdEn, byteEn, halfEn, wordEn, unsignedEn, addr[11:0], wrData}
  logic [49:0] exp_strobe_q[$];
  // resp entry: {is_load, rd, rdata}  (rd/rdata zero for stores)
  logic [37:0] exp_resp_q[$];
  // exc entry: {cause, addr}
  logic [35:0] exp_exc_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_strobe(input logic wr, rd, b, h, w, u, input logic [11:0] a,
                            input logic [31:0] d);
    exp_strobe_q.push_back({wr, rd, b, h, w, u, a, d});
  endtask

  task automatic exp_resp(input logic is_load, input logic [4:0] rd, input logic [31:0] d);
    exp_resp_q.push_back({is_load, rd, d});
  endtask

  task automatic exp_exc(input logic [3:0] cause, input logic [31:0] a);
    exp_exc_q.push_back({cause, a});
  endtask

  always @(negedge clk) begin : monitor
    logic [49:0] st;
    logic [37:0] rs;
    logic [35:0] ex;
    if (bus.mem_wrEn || bus.mem_rdEn) begin
      st = {bus.mem_wrEn, bus.mem_rdEn, bus.mem_byteEn, bus.mem_halfEn, bus.mem_wordEn,
            bus.mem_unsignedEn, bus.mem_addr, (bus.mem_wrEn ? bus.mem_wrData : 32'h0)};
      if (exp_strobe_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL strobe_unexpected actual=0x%0h required=none", st);
      end else begin
        check("strobe", 64'(st), 64'(exp_strobe_q.pop_front()));
      end
    end else begin
      check("flags_without_strobe",
            64'({bus.mem_byteEn, bus.mem_halfEn, bus.mem_wordEn, bus.mem_unsignedEn}), 64'(0));
    end
    if (bus.resp_valid) begin
      rs = {bus.resp_is_load, (bus.resp_is_load ? bus.resp_rd : 5'd0),
            (bus.resp_is_load ? bus.resp_rdata : 32'h0)};
      if (exp_resp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL resp_unexpected actual=0x%0h required=none", rs);
      end else begin
        check("resp", 64'(rs), 64'(exp_resp_q.pop_front()));
      end
    end
    if (bus.exc_valid) begin
      ex = {bus.exc_cause, bus.exc_addr};
      if (exp_exc_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL exc_unexpected actual=0x%0h required=none", ex);
      end else begin
        check("exc", 64'(ex), 64'(exp_exc_q.pop_front()));
      end
    end
  end

  // ---------------- RAM controller model ----------------
  logic        auto_resp = 1'b1;
  logic        stray_req = 1'b0;
  logic [31:0] ctrl_data = 32'h0;

  initial begin
    bus.mem_outEn   = 1'b0;
    bus.mem_dataOut = '0;
    forever begin
      @(negedge clk);
      if ((bus.mem_rdEn && auto_resp) || stray_req) begin
        @(posedge clk); #1;
        bus.mem_outEn   = 1'b1;
        bus.mem_dataOut = ctrl_data;
        @(posedge clk); #1;
        bus.mem_outEn   = 1'b0;
        bus.mem_dataOut = '0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Presents one op for a single cycle; called just after a rising edge.
  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] base,
                      input logic [11:0] imm, input logic [31:0] wd, input logic [4:0] rd);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_base     = base;
    bus.req_imm      = imm;
    bus.req_wdata    = wd;
    bus.req_rd       = rd;
    @(negedge clk);
    check("accept_ready", 64'(bus.req_ready), 64'(1));
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Counts falling edges until the pulse shows; returns at that falling edge.
  task automatic wait_for(input string name, input bit want_exc, input int want_n,
                          input int limit);
    int n    = 0;
    bit seen = 1'b0;
    while (!seen && n < limit) begin
      @(negedge clk);
      n++;
      seen = want_exc ? bus.exc_valid : bus.resp_valid;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=no_pulse required=pulse_within_%0d", name, limit);
    end else begin
      check({name, "_latency"}, 64'(n), 64'(want_n));
    end
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_req_ready"}, 64'(bus.req_ready), 64'(1));
    check({p, "_state"}, 64'(dbg_state), 64'(IDLE));
    check({p, "_pulses"}, 64'({bus.resp_valid, bus.exc_valid, bus.mem_wrEn, bus.mem_rdEn}), 64'(0));
    check({p, "_resp_data"}, 64'({bus.resp_rd, bus.resp_rdata}), 64'(0));
    check({p, "_exc_regs"}, 64'({bus.exc_cause, bus.exc_addr}), 64'(0));
    check({p, "_mem_regs"}, 64'({bus.mem_addr, bus.mem_wrData}), 64'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = '0;
    bus.req_base     = '0;
    bus.req_imm      = '0;
    bus.req_wdata    = '0;
    bus.req_rd       = '0;
    bus.flush        = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    tick();

    // LW 0x100+4: word read strobe, data back after the nominal 3-cycle latency.
    ctrl_data = 32'hDEADBEEF;
    exp_strobe(0, 1, 0, 0, 1, 0, 12'h104, 32'h0);
    exp_resp(1, 5'd5, 32'hDEADBEEF);
    send(0, F3_W, 32'h100, 12'h004, 32'h0, 5'd5);
    wait_for("lw", 0, 3, 10);
    tick(); idle(2);

    // SB, SH and an unassigned-funct3 store (word width, funct3[2] sign flag).
    exp_strobe(1, 0, 1, 0, 0, 0, 12'h007, 32'h000000AB);
    exp_resp(0, 5'd0, 32'h0);
    send(1, F3_B, 32'h0, 12'h007, 32'h123456AB, 5'd0);
    wait_for("sb", 0, 1, 4);
    tick();
    exp_strobe(1, 0, 0, 1, 0, 0, 12'h102, 32'h0000CDEF);
    exp_resp(0, 5'd0, 32'h0);
    send(1, F3_H, 32'h100, 12'h002, 32'h89ABCDEF, 5'd0);
    wait_for("sh", 0, 1, 4);
    tick();
    exp_strobe(1, 0, 0, 0, 1, 1, 12'h008, 32'h01020304);
    exp_resp(0, 5'd0, 32'h0);
    send(1, 3'b111, 32'h8, 12'h000, 32'h01020304, 5'd0);
    wait_for("st_f3_111", 0, 1, 4);
    tick();

    // LHU with negative offset: 0x200 - 2 = 0x1FE.
    ctrl_data = 32'h0000BEEF;
    exp_strobe(0, 1, 0, 1, 0, 1, 12'h1FE, 32'h0);
    exp_resp(1, 5'd7, 32'h0000BEEF);
    send(0, F3_HU, 32'h200, 12'hFFE, 32'h0, 5'd7);
    wait_for("lhu", 0, 3, 10);
    tick(); idle(2);

    // Misaligned accesses: exception next cycle, no strobe.
    exp_exc(EXC_LOAD_MISALIGNED, 32'h3);
    send(0, F3_H, 32'h0, 12'h003, 32'h0, 5'd1);
    wait_for("lh_mis", 1, 1, 4);
    tick();
    exp_exc(EXC_STORE_MISALIGNED, 32'h6);
    send(1, F3_W, 32'h10, 12'hFF6, 32'hFFFFFFFF, 5'd0);
    wait_for("sw_mis", 1, 1, 4);
    tick();
    exp_exc(EXC_LOAD_MISALIGNED, 32'h80000001);
    send(0, F3_W, 32'h80000000, 12'h001, 32'h0, 5'd2);
    wait_for("lw_mis", 1, 1, 4);
    tick();
    exp_exc(EXC_LOAD_MISALIGNED, 32'h2);
    send(0, 3'b011, 32'h0, 12'h002, 32'h0, 5'd2);
    wait_for("ld_f3_011_mis", 1, 1, 4);
    tick();

    // LBU with read data withheld: access fault once the wait budget runs out.
    auto_resp = 1'b0;
    exp_strobe(0, 1, 1, 0, 0, 1, 12'h021, 32'h0);
    exp_exc(EXC_LOAD_ACCESS_FAULT, 32'h21);
    send(0, F3_BU, 32'h20, 12'h001, 32'h0, 5'd3);
    @(negedge clk);
    check("rd_wait_ready", 64'(bus.req_ready), 64'(0));
    check("rd_wait_state", 64'(dbg_state), 64'(RD_WAIT));
    // First waiting cycle already consumed above: fault lands TIMEOUT+1 cycles after accept.
    wait_for("lbu_fault", 1, TIMEOUT, 20);
    check("fault_ready", 64'(bus.req_ready), 64'(1));
    tick();
    auto_resp = 1'b1;

    // LW flushed while waiting: the returning beat is swallowed.
    ctrl_data = 32'h11111111;
    exp_strobe(0, 1, 0, 0, 1, 0, 12'h040, 32'h0);
    send(0, F3_W, 32'h40, 12'h000, 32'h0, 5'd9);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    check("drain_ready", 64'(bus.req_ready), 64'(0));
    check("drain_state", 64'(dbg_state), 64'(DRAIN));
    tick();
    @(negedge clk);
    check("post_drain_state", 64'(dbg_state), 64'(IDLE));
    tick(); idle(3);

    // Flush in IDLE kills a same-cycle store.
    bus.req_valid    = 1'b1;
    bus.req_is_store = 1'b1;
    bus.req_funct3   = F3_W;
    bus.req_base     = 32'h300;
    bus.req_imm      = 12'h0;
    bus.req_wdata    = 32'h55555555;
    bus.flush        = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    idle(3);

    exp_strobe(1, 0, 0, 0, 1, 0, 12'h084, 32'hCAFEF00D);
    exp_resp(0, 5'd0, 32'h0);
    send(1, F3_W, 32'h80, 12'h004, 32'hCAFEF00D, 5'd0);
    wait_for("sw_after_flush", 0, 1, 4);
    tick();

    // Address wrap 0xFFFFFFFC+8 = 0x4, then reset while waiting for data.
    auto_resp = 1'b0;
    exp_strobe(0, 1, 0, 0, 1, 0, 12'h004, 32'h0);
    send(0, F3_W, 32'hFFFFFFFC, 12'h008, 32'h0, 5'd4);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    tick();

    // Stray read-data beat while IDLE must be ignored.
    stray_req = 1'b1;
    @(negedge clk);
    tick();
    stray_req = 1'b0;
    idle(3);
    @(negedge clk);
    check("stray_state", 64'(dbg_state), 64'(IDLE));
    tick();
    auto_resp = 1'b1;

    // ---------------- final report ----------------
    check("strobe_q_empty", 64'(exp_strobe_q.size()), 64'(0));
    check("resp_q_empty", 64'(exp_resp_q.size()), 64'(0));
    check("exc_q_empty", 64'(exp_exc_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
